// File: rtl/gpio_handshake_responder.sv
// Off-chip GPIO transactor stand-in: watches mprj_io[31:24], answers the firmware handshake on
// mprj_io[23:16] and flags pass/fail. Define GPIO_RESP_FILTER_EN to require 4-cycle stable matches.
module gpio_handshake_responder #(
  parameter int HOLD_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] gpio_hi,
  output logic [7:0] gpio_lo_out,
  output logic       gpio_lo_oe,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] state
);
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [14:0]   TMO_LAST  = 15'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_R1 = 4'd1, S_R2 = 4'd2, S_R3 = 4'd3, S_R4 = 4'd4,
    S_M1 = 4'd5, S_M2 = 4'd6, S_M3 = 4'd7, S_PASS = 4'd8, S_FAIL = 4'd9
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    hi_m_q, hi_s_q;
  logic [HW-1:0] hold_q, hold_d;
  logic [14:0]   tmo_q, tmo_d;
  logic [2:0]    seen_q, seen_d;
  logic [7:0]    lo_out_q, lo_out_d;
  logic          oe_q, oe_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [7:0]    awaited;
  logic          awaiting, hit, match;

  always_comb begin
    awaiting = 1'b1;
    awaited  = 8'h00;
    case (state_q)
      S_IDLE:  awaited = 8'hA0;
      S_R1:    awaited = 8'h0B;
      S_R2:    awaited = 8'hAB;
      S_M1:    awaited = 8'h01;
      S_M2:    awaited = 8'h02;
      S_M3:    awaited = 8'h04;
      default: awaiting = 1'b0;
    endcase
  end

  assign hit = awaiting && (hi_s_q == awaited);

`ifdef GPIO_RESP_FILTER_EN
  // Stability count of the awaited value; restarts whenever the awaited value changes.
  logic [1:0] stab_q, stab_d;
  always_comb begin
    stab_d = 2'd0;
    if (hit && (state_d == state_q)) stab_d = (stab_q == 2'd3) ? stab_q : stab_q + 2'd1;
  end
  assign match = hit && (stab_q == 2'd3);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stab_q <= 2'd0;
    else       stab_q <= stab_d;
  end
`else
  assign match = hit;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    seen_d  = seen_q;
    case (state_q)
      S_IDLE: if (match) state_d = S_R1;
      S_R1:   if (match) state_d = S_R2;
      S_R2: if (match) begin
        state_d = S_R3;
        hold_d  = HOLD_LOAD;
      end
      S_R3: if (hold_q == '0) begin
        state_d = S_R4;
        hold_d  = HOLD_LOAD;
      end else hold_d = hold_q - HW'(1);
      S_R4: if (hold_q == '0) state_d = S_M1;
            else              hold_d  = hold_q - HW'(1);
      // Reports already latched during the hold phase skip their wait states.
      S_M1: if (seen_q[0] || match) state_d = seen_q[1] ? (seen_q[2] ? S_PASS : S_M3) : S_M2;
      S_M2: if (seen_q[1] || match) state_d = seen_q[2] ? S_PASS : S_M3;
      S_M3: if (seen_q[2] || match) state_d = S_PASS;
      default: ;
    endcase
    if (state_q == S_R3 || state_q == S_R4) begin
      if (hi_s_q == 8'h01) seen_d[0] = 1'b1;
      if (hi_s_q == 8'h02) seen_d[1] = 1'b1;
      if (hi_s_q == 8'h04) seen_d[2] = 1'b1;
    end
    // A final match on the timeout cycle still passes.
    if (state_q != S_PASS && state_q != S_FAIL && state_d != S_PASS && tmo_q == TMO_LAST)
      state_d = S_FAIL;
    tmo_d = (state_q == S_PASS || state_q == S_FAIL) ? tmo_q : tmo_q + 15'd1;
  end

  always_comb begin
    oe_d     = (state_d != S_IDLE);
    lo_out_d = lo_out_q;
    case (state_d)
      S_IDLE, S_R3:     lo_out_d = 8'h00;
      S_R1:             lo_out_d = 8'hF0;
      S_R2:             lo_out_d = 8'h0F;
      S_R4:             lo_out_d = 8'h01;
      S_M1, S_M2, S_M3: lo_out_d = 8'h03;
      default: ;
    endcase
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
    done_d = pass_d | fail_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_m_q   <= 8'h00;
      hi_s_q   <= 8'h00;
      state_q  <= S_IDLE;
      hold_q   <= '0;
      tmo_q    <= 15'd0;
      seen_q   <= 3'b000;
      lo_out_q <= 8'h00;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      hi_m_q   <= gpio_hi;
      hi_s_q   <= hi_m_q;
      state_q  <= state_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      lo_out_q <= lo_out_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  assign gpio_lo_out = lo_out_q;
  assign gpio_lo_oe  = oe_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign state       = state_q;
endmodule

// File: tb/tb_gpio_handshake_responder.sv
// Scoreboard bench for gpio_handshake_responder (HOLD_CYCLES=8, TIMEOUT_CYCLES=100).
module tb_gpio_handshake_responder;
  localparam int HOLD = 8;
  localparam int TMO  = 100;
`ifdef GPIO_RESP_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] gpio_hi;
  logic [7:0] gpio_lo_out;
  logic       gpio_lo_oe, done, pass, fail;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] out;
    logic       oe;
  } exp_t;
  exp_t sb[$];

  gpio_handshake_responder #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .gpio_hi(gpio_hi), .gpio_lo_out(gpio_lo_out),
    .gpio_lo_oe(gpio_lo_oe), .done(done), .pass(pass), .fail(fail), .state(state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    gpio_hi = 8'h00;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, output bit ok);
    int n = 0;
    while (state !== s && n < 200) begin
      tick(1);
      n++;
    end
    ok = (state === s);
  endtask

  task automatic drive_prefix();
    gpio_hi = 8'hA0; tick(LAT + 1);
    gpio_hi = 8'h0B; tick(LAT + 1);
    gpio_hi = 8'hAB; tick(LAT + 1);
  endtask

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    gpio_hi = 8'h00;
    #3;
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe, done, pass, fail} !== 16'h0) begin
      failures++;
      $display("FAIL reset_values: got st=%0d out=%h oe=%0d done=%0d pass=%0d fail=%0d, want all 0",
               state, gpio_lo_out, gpio_lo_oe, done, pass, fail);
    end
    tick(2);
    reset = 1'b0;
    tick(4);
    checks++;
    if (state !== 4'd0 || gpio_lo_oe !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got st=%0d oe=%0d, want st=0 oe=0", state, gpio_lo_oe);
    end
    gpio_hi = 8'hA0;
    sb.push_back('{st: 4'd1, out: 8'hF0, oe: 1'b1});
    tick(LAT - 1);
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL a0_latency_early: got st=%0d, want st=0", state);
    end
    tick(1);
    e = sb.pop_front();
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe} !== e) begin
      failures++;
      $display("FAIL a0_latency: got st=%0d out=%h oe=%0d, want st=%0d out=%h oe=%0d",
               state, gpio_lo_out, gpio_lo_oe, e.st, e.out, e.oe);
    end
  endtask

  task automatic test_transient();
    apply_reset();
    gpio_hi = 8'h0B; tick(1);
    gpio_hi = 8'hAB; tick(1);
    gpio_hi = 8'h00; tick(LAT + 3);
    checks++;
    if (state !== 4'd0 || gpio_lo_oe !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL transient_ignored: got st=%0d oe=%0d fail=%0d, want st=0 oe=0 fail=0",
               state, gpio_lo_oe, fail);
    end
  endtask

  task automatic test_full_sequence();
    logic [7:0] hi_t[6];
    exp_t       ex_t[6];
    exp_t       e;
    int         n;
    hi_t = '{8'hA0, 8'h0B, 8'hAB, 8'h01, 8'h02, 8'h04};
    ex_t = '{'{4'd1, 8'hF0, 1'b1}, '{4'd2, 8'h0F, 1'b1}, '{4'd3, 8'h00, 1'b1},
             '{4'd6, 8'h03, 1'b1}, '{4'd7, 8'h03, 1'b1}, '{4'd8, 8'h03, 1'b1}};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        // hold phases: 00 then 01, each for exactly HOLD cycles, then 03 in M1
        n = 0;
        while (state === 4'd3 && n < 100) begin n++; tick(1); end
        checks++;
        if (n !== HOLD || state !== 4'd4 || gpio_lo_out !== 8'h01) begin
          failures++;
          $display("FAIL r3_hold: got cycles=%0d st=%0d out=%h, want cycles=%0d st=4 out=01",
                   n, state, gpio_lo_out, HOLD);
        end
        n = 0;
        while (state === 4'd4 && n < 100) begin n++; tick(1); end
        checks++;
        if (n !== HOLD || state !== 4'd5 || gpio_lo_out !== 8'h03) begin
          failures++;
          $display("FAIL r4_hold: got cycles=%0d st=%0d out=%h, want cycles=%0d st=5 out=03",
                   n, state, gpio_lo_out, HOLD);
        end
      end
      gpio_hi = hi_t[i];
      sb.push_back(ex_t[i]);
      tick(LAT);
      e = sb.pop_front();
      checks++;
      if ({state, gpio_lo_out, gpio_lo_oe} !== e) begin
        failures++;
        $display("FAIL seq_step%0d: got st=%0d out=%h oe=%0d, want st=%0d out=%h oe=%0d",
                 i, state, gpio_lo_out, gpio_lo_oe, e.st, e.out, e.oe);
      end
    end
    checks++;
    if ({pass, done, fail} !== 3'b110) begin
      failures++;
      $display("FAIL seq_flags: got pass=%0d done=%0d fail=%0d, want 1 1 0", pass, done, fail);
    end
    gpio_hi = 8'hA0;
    tick(TMO + 10);
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe, pass, fail} !== {4'd8, 8'h03, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL pass_terminal: got st=%0d out=%h oe=%0d pass=%0d fail=%0d, want 8 03 1 1 0",
               state, gpio_lo_out, gpio_lo_oe, pass, fail);
    end
  endtask

  task automatic test_early_reports();
    exp_t e;
    bit   ok;
    apply_reset();
    drive_prefix();
    wait_state(4'd3, ok);
    gpio_hi = 8'h01; tick(2);
    gpio_hi = 8'h02; tick(2);
    gpio_hi = 8'h04; tick(2);
    sb.push_back('{st: 4'd8, out: 8'h03, oe: 1'b1});
    wait_state(4'd5, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL early_m1_reach: got st=%0d, want st=5", state);
    end
    tick(1);
    e = sb.pop_front();
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe} !== e || pass !== 1'b1) begin
      failures++;
      $display("FAIL early_skip: got st=%0d out=%h oe=%0d pass=%0d, want st=%0d out=%h oe=%0d pass=1",
               state, gpio_lo_out, gpio_lo_oe, pass, e.st, e.out, e.oe);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    reset   = 1'b1;
    gpio_hi = 8'hA0;
    tick(1);
    reset = 1'b0;
    sb.push_back('{st: 4'd9, out: 8'hF0, oe: 1'b1});
    tick(TMO - 1);
    checks++;
    if (state !== 4'd1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got st=%0d fail=%0d, want st=1 fail=0", state, fail);
    end
    tick(1);
    e = sb.pop_front();
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe} !== e || {fail, done, pass} !== 3'b110) begin
      failures++;
      $display("FAIL timeout: got st=%0d out=%h oe=%0d fail=%0d done=%0d pass=%0d, want st=%0d out=%h oe=%0d 1 1 0",
               state, gpio_lo_out, gpio_lo_oe, fail, done, pass, e.st, e.out, e.oe);
    end
    gpio_hi = 8'h0B;
    tick(10);
    checks++;
    if (state !== 4'd9 || gpio_lo_out !== 8'hF0) begin
      failures++;
      $display("FAIL fail_terminal: got st=%0d out=%h, want st=9 out=F0", state, gpio_lo_out);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    apply_reset();
    drive_prefix();
    wait_state(4'd4, ok);
    tick(2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe, done, pass, fail} !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset: got st=%0d out=%h oe=%0d done=%0d pass=%0d fail=%0d, want all 0",
               state, gpio_lo_out, gpio_lo_oe, done, pass, fail);
    end
    gpio_hi = 8'h00;
    tick(1);
    reset = 1'b0;
    drive_prefix();
    wait_state(4'd5, ok);
    gpio_hi = 8'h01; tick(LAT + 1);
    gpio_hi = 8'h02; tick(LAT + 1);
    gpio_hi = 8'h04; tick(LAT + 1);
    checks++;
    if (state !== 4'd8 || {pass, done, fail} !== 3'b110) begin
      failures++;
      $display("FAIL replay: got st=%0d pass=%0d done=%0d fail=%0d, want st=8 1 1 0",
               state, pass, done, fail);
    end
  endtask

`ifdef GPIO_RESP_FILTER_EN
  task automatic test_filter();
    exp_t e;
    apply_reset();
    gpio_hi = 8'hA0; tick(3);
    gpio_hi = 8'h00; tick(8);
    checks++;
    if (state !== 4'd0 || gpio_lo_oe !== 1'b0) begin
      failures++;
      $display("FAIL filter_glitch: got st=%0d oe=%0d, want st=0 oe=0", state, gpio_lo_oe);
    end
    gpio_hi = 8'hA0;
    sb.push_back('{st: 4'd1, out: 8'hF0, oe: 1'b1});
    tick(6);
    e = sb.pop_front();
    checks++;
    if ({state, gpio_lo_out, gpio_lo_oe} !== e) begin
      failures++;
      $display("FAIL filter_hold: got st=%0d out=%h oe=%0d, want st=%0d out=%h oe=%0d",
               state, gpio_lo_out, gpio_lo_oe, e.st, e.out, e.oe);
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    gpio_hi = 8'h00;
    test_reset();
    test_transient();
    test_full_sequence();
    test_early_reports();
    test_timeout();
    test_mid_reset();
`ifdef GPIO_RESP_FILTER_EN
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
